// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of the APB master bridge.
// The master modport is the bridge's view; the slave modport is the view of whatever sits around it.
interface apb_master_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns one valid/ready command into a SETUP/ACCESS
// transfer, honours PREADY wait states, aborts hung transfers and returns a response.
module apb_master_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_master_bridge_if.master bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [CNT_W-1:0]  w_cnt_inc;

   // Wait-state counter saturates at TIMEOUT instead of wrapping
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_pwrite    <= bus.cmd_write;
                  r_paddr     <= bus.cmd_addr;
                  r_pwdata    <= bus.cmd_wdata;
                  r_psel      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               // Completion takes priority over a timeout landing on the same edge
               if (bus.PREADY) begin
                  r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CNT_MAX) begin
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_psel      <= 1'b0;
                     r_penable   <= 1'b0;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_cnt       <= '0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.PSELx     = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a driver queues expected responses from a
// memory model, a slave model answers on APB, and a monitor checks bus and responses.
module tb_apb_master_bridge;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam int STUCK = 1000;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      logic        err;
      int          ac;
      int          acc_edge;
   } xfer_t;

   logic PCLK;
   logic PRESETn;

   apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus.master)
   );

   xfer_t       exp_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];
   int n_checks;
   int n_fail;
   int cyc;
   int s_acnt;
   int s_w;
   bit m_prev_setup;
   bit m_in_xfer;
   bit m_rsp_seen;
   bit m_ready_next;
   int m_acc_cnt;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_write;

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always @(posedge PCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
      $fatal(1);
   end

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return ~a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver: presents one command, and on acceptance queues the response the spec predicts
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int waits);
      xfer_t t;
      bit    ok;
      bit    done;
      ok = 1'b0;
      @(negedge PCLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      for (int k = 0; k < 200 && !ok; k++) begin
         #2;
         if (bus.cmd_ready) begin
            done       = (waits < int'(TIMEOUT));
            t.write    = wr;
            t.addr     = a;
            t.wdata    = wd;
            t.waits    = waits;
            t.err      = !done;
            t.ac       = done ? waits + 1 : int'(TIMEOUT);
            t.acc_edge = cyc + 1;
            t.rdata    = (wr || !done) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
            if (wr && done) ref_mem[a] = wd;
            exp_q.push_back(t);
            ok = 1'b1;
         end else begin
            @(negedge PCLK);
         end
      end
      check("cmd_accept", 64'(ok), 64'(1));
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge PCLK);
         #3;
         if (exp_q.size() == 0 && bus.cmd_ready) ok = 1'b1;
      end
      check("drain", 64'(ok), 64'(1));
   endtask

   // APB slave model: register file with per-transfer wait states
   initial begin
      bus.PREADY = 1'b0;
      bus.PRDATA = '0;
      s_acnt = 0;
      forever begin
         @(negedge PCLK);
         if (bus.PSELx && bus.PENABLE) begin
            s_w = (exp_q.size() > 0) ? exp_q[0].waits : 0;
            if (s_acnt == s_w) begin
               bus.PREADY = 1'b1;
               if (bus.PWRITE) begin
                  slv_mem[bus.PADDR] = bus.PWDATA;
                  bus.PRDATA = $urandom;
               end else begin
                  bus.PRDATA = slv_mem.exists(bus.PADDR) ? slv_mem[bus.PADDR] : dflt(bus.PADDR);
               end
            end else begin
               bus.PREADY = 1'b0;
               bus.PRDATA = $urandom;
            end
            s_acnt++;
         end else begin
            bus.PREADY = 1'b0;
            bus.PRDATA = $urandom;
            s_acnt = 0;
         end
      end
   end

   // Monitor: samples mid-cycle, checks protocol and pops the scoreboard on handshakes
   initial begin
      forever begin
         @(negedge PCLK);
         #2;
         if (!PRESETn) begin
            m_prev_setup = 1'b0;
            m_in_xfer    = 1'b0;
            m_rsp_seen   = 1'b0;
            m_ready_next = 1'b0;
            continue;
         end
         check("penable_without_psel", 64'(bus.PENABLE && !bus.PSELx), 64'(0));
         check("cmd_ready_when_idle", 64'(bus.cmd_ready), 64'(!(bus.PSELx || bus.rsp_valid)));
         if (m_ready_next) check("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'(1));
         m_ready_next = 1'b0;
         if (m_prev_setup) check("setup_then_access", 64'(bus.PSELx && bus.PENABLE), 64'(1));
         m_prev_setup = 1'b0;
         if (bus.PSELx && !bus.PENABLE) begin
            check("single_setup", 64'(m_in_xfer), 64'(0));
            check("setup_has_cmd", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
               check("setup_paddr", 64'(bus.PADDR), 64'(exp_q[0].addr));
               check("setup_pwrite", 64'(bus.PWRITE), 64'(exp_q[0].write));
               if (exp_q[0].write) check("setup_pwdata", 64'(bus.PWDATA), 64'(exp_q[0].wdata));
               check("setup_cycle", 64'(cyc), 64'(exp_q[0].acc_edge));
            end
            m_addr = bus.PADDR;
            m_write = bus.PWRITE;
            m_wdata = bus.PWDATA;
            m_in_xfer = 1'b1;
            m_acc_cnt = 0;
            m_prev_setup = 1'b1;
         end
         if (bus.PSELx && bus.PENABLE) begin
            m_acc_cnt++;
            check("paddr_stable", 64'(bus.PADDR), 64'(m_addr));
            check("pwrite_stable", 64'(bus.PWRITE), 64'(m_write));
            check("pwdata_stable", 64'(bus.PWDATA), 64'(m_wdata));
         end
         if (bus.rsp_valid) begin
            check("no_setup_during_rsp", 64'(bus.PSELx), 64'(0));
            check("rsp_has_cmd", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
               check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0].rdata));
               check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
               if (!m_rsp_seen) begin
                  // SETUP, then ac ACCESS cycles, then the response
                  check("rsp_latency", 64'(cyc), 64'(exp_q[0].acc_edge + 1 + exp_q[0].ac));
                  check("access_cycles", 64'(m_acc_cnt), 64'(exp_q[0].ac));
               end
               m_rsp_seen = 1'b1;
               if (bus.rsp_ready) begin
                  void'(exp_q.pop_front());
                  m_in_xfer = 1'b0;
                  m_rsp_seen = 1'b0;
                  m_ready_next = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      bit found;
      PRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      ref_mem[32'h8] = 32'h1234_5678;
      slv_mem[32'h8] = 32'h1234_5678;

      repeat (3) @(negedge PCLK);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("rst_psel", 64'(bus.PSELx), 64'(0));
      check("rst_penable", 64'(bus.PENABLE), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
      check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
      check("rst_paddr", 64'(bus.PADDR), 64'(0));
      check("rst_pwrite", 64'(bus.PWRITE), 64'(0));
      check("rst_pwdata", 64'(bus.PWDATA), 64'(0));
      PRESETn = 1'b1;

      // Zero-wait write, then a read with three wait states
      issue(1'b1, 32'h4, 32'hDEAD_BEEF, 0);
      wait_idle();
      issue(1'b0, 32'h8, 32'h0, 3);
      wait_idle();

      // Timeout boundaries: stuck slave, last-cycle completion, exactly TIMEOUT waits
      issue(1'b0, 32'h10, 32'h0, STUCK);
      wait_idle();
      issue(1'b0, 32'h30, 32'h0, int'(TIMEOUT) - 1);
      wait_idle();
      issue(1'b1, 32'h38, 32'hAAAA_5555, int'(TIMEOUT));
      wait_idle();
      issue(1'b0, 32'h38, 32'h0, 0);
      wait_idle();

      // Response back-pressure for five cycles
      bus.rsp_ready = 1'b0;
      issue(1'b1, 32'h40, 32'h0BAD_F00D, 2);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge PCLK);
         #3;
         if (bus.rsp_valid) found = 1'b1;
      end
      check("bp_rsp_seen", 64'(found), 64'(1));
      repeat (5) @(negedge PCLK);
      bus.rsp_ready = 1'b1;
      wait_idle();

      // Reset in the middle of a stalled ACCESS
      issue(1'b0, 32'h20, 32'h0, STUCK);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge PCLK);
         #3;
         if (bus.PENABLE) found = 1'b1;
      end
      check("mid_access_seen", 64'(found), 64'(1));
      @(negedge PCLK);
      #1 PRESETn = 1'b0;
      #1;
      check("mid_rst_psel", 64'(bus.PSELx), 64'(0));
      check("mid_rst_penable", 64'(bus.PENABLE), 64'(0));
      check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("mid_rst_paddr", 64'(bus.PADDR), 64'(0));
      exp_q.delete();
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      issue(1'b1, 32'h24, 32'h7777_1111, 0);
      wait_idle();
      issue(1'b0, 32'h24, 32'h0, 1);
      wait_idle();

      // Back-to-back random traffic
      for (int i = 0; i < 100; i++) begin
         logic [31:0] a;
         a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         issue(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)));
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
